// File: rtl/branch_rs_pkg.sv
// Shared widths, opcode encodings and entry payload type for the branch reservation station.
// No logic here; latency and backpressure are properties of the modules that import it.
package branch_rs_pkg;

  localparam int DEF_RS_SIZE = 8;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_NCDB    = 3;
  localparam int OP_W        = 4;
  localparam int DATA_W      = 32;

  localparam logic [OP_W-1:0] OP_NULL = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'd1;
  localparam logic [OP_W-1:0] OP_BNE  = 4'd2;
  localparam logic [OP_W-1:0] OP_BLT  = 4'd3;
  localparam logic [OP_W-1:0] OP_BGE  = 4'd4;
  localparam logic [OP_W-1:0] OP_BLTU = 4'd5;
  localparam logic [OP_W-1:0] OP_BGEU = 4'd6;
  localparam logic [OP_W-1:0] OP_JAL  = 4'd7;
  localparam logic [OP_W-1:0] OP_JALR = 4'd8;

  // Operand-independent part of an entry; travels unchanged from dispatch to issue.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } br_info_t;

endpackage

// File: rtl/branch_rs_priority_enc.sv
// Lowest-index set-bit finder; combinational, zero latency.
// No backpressure: found=0 with idx=0 when the request vector is empty.
module rs_priority_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest requesting index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_rs.sv
// Branch/jump reservation station: CDB wakeup, index-priority issue; ready dispatch issues one edge later.
// Backpressure: rs_full refuses dispatch, rdy_in low freezes entries, clear_in flushes everything.
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int RS_SIZE = DEF_RS_SIZE,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int NCDB    = DEF_NCDB
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   disp_valid,
  input  logic [OP_W-1:0]        disp_op,
  input  logic [TAG_W-1:0]       disp_qj,
  input  logic [TAG_W-1:0]       disp_qk,
  input  logic [DATA_W-1:0]      disp_vj,
  input  logic [DATA_W-1:0]      disp_vk,
  input  logic [TAG_W-1:0]       disp_dest,
  input  logic [DATA_W-1:0]      disp_imm,
  input  logic [DATA_W-1:0]      disp_pc,
  output logic                   rs_full,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic                   BranchRS_enable,
  output logic [OP_W-1:0]        BranchRS_op,
  output logic [DATA_W-1:0]      BranchRS_reg1,
  output logic [DATA_W-1:0]      BranchRS_reg2,
  output logic [TAG_W-1:0]       BranchRS_dest_rob,
  output logic [DATA_W-1:0]      BranchRS_imm,
  output logic [DATA_W-1:0]      BranchRS_pc
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [TAG_W-1:0]   qj   [RS_SIZE];
  logic [TAG_W-1:0]   qk   [RS_SIZE];
  logic [DATA_W-1:0]  vj   [RS_SIZE];
  logic [DATA_W-1:0]  vk   [RS_SIZE];
  logic [TAG_W-1:0]   dest [RS_SIZE];
  br_info_t           info [RS_SIZE];

  logic [TAG_W-1:0]   cdb_tag_a [NCDB];
  logic [DATA_W-1:0]  cdb_dat_a [NCDB];

  logic [RS_SIZE-1:0] ready_vec;
  logic               free_vld;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_fire;

  logic [TAG_W-1:0]   fwd_qj;
  logic [TAG_W-1:0]   fwd_qk;
  logic [DATA_W-1:0]  fwd_vj;
  logic [DATA_W-1:0]  fwd_vk;

  for (genvar b = 0; b < NCDB; b++) begin : g_cdb
    assign cdb_tag_a[b] = cdb_tag[b*TAG_W +: TAG_W];
    assign cdb_dat_a[b] = cdb_data[b*DATA_W +: DATA_W];
  end

  // Selection uses registered state only, so a same-cycle wakeup issues one edge later.
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ready
    assign ready_vec[i] = busy[i] && (qj[i] == '0) && (qk[i] == '0);
  end

  rs_priority_enc #(.N(RS_SIZE)) u_free_enc (
    .req   (~busy),
    .found (free_vld),
    .idx   (free_idx)
  );

  rs_priority_enc #(.N(RS_SIZE)) u_sel_enc (
    .req   (ready_vec),
    .found (sel_vld),
    .idx   (sel_idx)
  );

  assign rs_full   = ~free_vld;
  assign disp_fire = disp_valid && !rs_full;

  // Same-cycle forwarding; descending scan lets the lowest bus index win a tag tie.
  always_comb begin
    fwd_qj = disp_qj;
    fwd_qk = disp_qk;
    fwd_vj = disp_vj;
    fwd_vk = disp_vk;
    for (int b = NCDB - 1; b >= 0; b--) begin
      if (cdb_valid[b] && (disp_qj != '0) && (disp_qj == cdb_tag_a[b])) begin
        fwd_qj = '0;
        fwd_vj = cdb_dat_a[b];
      end
      if (cdb_valid[b] && (disp_qk != '0) && (disp_qk == cdb_tag_a[b])) begin
        fwd_qk = '0;
        fwd_vk = cdb_dat_a[b];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy              <= '0;
      BranchRS_enable   <= 1'b0;
      BranchRS_op       <= '0;
      BranchRS_reg1     <= '0;
      BranchRS_reg2     <= '0;
      BranchRS_dest_rob <= '0;
      BranchRS_imm      <= '0;
      BranchRS_pc       <= '0;
    end else if (clear_in) begin
      busy            <= '0;
      BranchRS_enable <= 1'b0;
    end else if (!rdy_in) begin
      BranchRS_enable <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        for (int b = NCDB - 1; b >= 0; b--) begin
          if (busy[i] && cdb_valid[b] && (qj[i] != '0) && (qj[i] == cdb_tag_a[b])) begin
            qj[i] <= '0;
            vj[i] <= cdb_dat_a[b];
          end
          if (busy[i] && cdb_valid[b] && (qk[i] != '0) && (qk[i] == cdb_tag_a[b])) begin
            qk[i] <= '0;
            vk[i] <= cdb_dat_a[b];
          end
        end
      end

      if (sel_vld) begin
        BranchRS_enable   <= 1'b1;
        BranchRS_op       <= info[sel_idx].op;
        BranchRS_reg1     <= vj[sel_idx];
        BranchRS_reg2     <= vk[sel_idx];
        BranchRS_dest_rob <= dest[sel_idx];
        BranchRS_imm      <= info[sel_idx].imm;
        BranchRS_pc       <= info[sel_idx].pc;
        busy[sel_idx]     <= 1'b0;
      end else begin
        BranchRS_enable <= 1'b0;
      end

      // free_idx comes from pre-edge busy bits, so it never aliases the slot issuing now.
      if (disp_fire) begin
        busy[free_idx] <= 1'b1;
        qj[free_idx]   <= fwd_qj;
        qk[free_idx]   <= fwd_qk;
        vj[free_idx]   <= fwd_vj;
        vk[free_idx]   <= fwd_vk;
        dest[free_idx] <= disp_dest;
        info[free_idx] <= '{op: disp_op, imm: disp_imm, pc: disp_pc};
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: expected issues are queued at dispatch and checked on BranchRS_enable.
module tb_branch_rs;
  import branch_rs_pkg::*;

  localparam int TW = DEF_TAG_W;
  localparam int NC = DEF_NCDB;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clear_in;
  logic              disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [TW-1:0]     disp_qj;
  logic [TW-1:0]     disp_qk;
  logic [31:0]       disp_vj;
  logic [31:0]       disp_vk;
  logic [TW-1:0]     disp_dest;
  logic [31:0]       disp_imm;
  logic [31:0]       disp_pc;
  logic              rs_full;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*32-1:0]  cdb_data;
  logic              BranchRS_enable;
  logic [OP_W-1:0]   BranchRS_op;
  logic [31:0]       BranchRS_reg1;
  logic [31:0]       BranchRS_reg2;
  logic [TW-1:0]     BranchRS_dest_rob;
  logic [31:0]       BranchRS_imm;
  logic [31:0]       BranchRS_pc;

  always #5 clk_in = ~clk_in;

  branch_rs dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_in          (clear_in),
    .disp_valid        (disp_valid),
    .disp_op           (disp_op),
    .disp_qj           (disp_qj),
    .disp_qk           (disp_qk),
    .disp_vj           (disp_vj),
    .disp_vk           (disp_vk),
    .disp_dest         (disp_dest),
    .disp_imm          (disp_imm),
    .disp_pc           (disp_pc),
    .rs_full           (rs_full),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .BranchRS_enable   (BranchRS_enable),
    .BranchRS_op       (BranchRS_op),
    .BranchRS_reg1     (BranchRS_reg1),
    .BranchRS_reg2     (BranchRS_reg2),
    .BranchRS_dest_rob (BranchRS_dest_rob),
    .BranchRS_imm      (BranchRS_imm),
    .BranchRS_pc       (BranchRS_pc)
  );

  typedef struct {
    logic [OP_W-1:0] op;
    logic [31:0]     r1;
    logic [31:0]     r2;
    logic [TW-1:0]   dest;
    logic [31:0]     imm;
    logic [31:0]     pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_issue(input logic [OP_W-1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [TW-1:0] dest, input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.r1 = r1; e.r2 = r2; e.dest = dest; e.imm = imm; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op, input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                          input logic [31:0] vj, input logic [31:0] vk, input logic [TW-1:0] dest,
                          input logic [31:0] imm, input logic [31:0] pc);
    disp_valid = 1'b1;
    disp_op = op; disp_qj = qj; disp_qk = qk; disp_vj = vj; disp_vk = vk;
    disp_dest = dest; disp_imm = imm; disp_pc = pc;
    step(1);
    disp_valid = 1'b0;
  endtask

  task automatic set_cdb(input int bus, input logic [TW-1:0] tag, input logic [31:0] data);
    cdb_valid[bus]           = 1'b1;
    cdb_tag[bus*TW +: TW]    = tag;
    cdb_data[bus*32 +: 32]   = data;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0;
  endtask

  // Every issue must match the head of the scoreboard; an issue with nothing queued is an error.
  always @(negedge clk_in) begin
    if (BranchRS_enable === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {31'b0, BranchRS_enable}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("iss_op",   {28'b0, BranchRS_op},       {28'b0, mon_e.op});
        check("iss_reg1", BranchRS_reg1,              mon_e.r1);
        check("iss_reg2", BranchRS_reg2,              mon_e.r2);
        check("iss_dest", {28'b0, BranchRS_dest_rob}, {28'b0, mon_e.dest});
        check("iss_imm",  BranchRS_imm,               mon_e.imm);
        check("iss_pc",   BranchRS_pc,                mon_e.pc);
      end
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0;
    disp_op = '0; disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0;
    disp_dest = '0; disp_imm = '0; disp_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    step(2);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_full", {31'b0, rs_full}, 32'd0);
    check("rst_en",   {31'b0, BranchRS_enable}, 32'd0);
    check("rst_op",   {28'b0, BranchRS_op}, 32'd0);
    check("rst_pc",   BranchRS_pc, 32'd0);
    check("rst_reg1", BranchRS_reg1, 32'd0);

    // Reset mid-operation: stalled entries must vanish.
    for (int i = 0; i < 3; i++) dispatch(OP_BEQ, 4'd9, 4'd0, 32'd0, 32'd1, 4'(i + 1), 32'd0, 32'h40);
    rst_in = 1'b0;
    step(1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("t1_full", {31'b0, rs_full}, 32'd0);
    check("t1_en",   {31'b0, BranchRS_enable}, 32'd0);
    for (int i = 0; i < 5; i++) dispatch(OP_BNE, 4'd12, 4'd0, 32'd0, 32'd1, 4'(i + 1), 32'd0, 32'h50);
    @(negedge clk_in);
    check("t1_five_not_full", {31'b0, rs_full}, 32'd0);
    rst_in = 1'b0;
    step(1);
    rst_in = 1'b1;
    set_cdb(0, 4'd9, 32'h99);
    set_cdb(2, 4'd12, 32'h12);
    step(1);
    clr_cdb();
    step(3);
    @(negedge clk_in);
    check("t1_no_issue", {31'b0, BranchRS_enable}, 32'd0);

    // Ready dispatch: one-edge latency, single-cycle pulse, data holds.
    expect_issue(OP_BEQ, 32'd5, 32'd5, 4'd3, 32'd8, 32'h100);
    dispatch(OP_BEQ, 4'd0, 4'd0, 32'd5, 32'd5, 4'd3, 32'd8, 32'h100);
    @(negedge clk_in);
    check("t2_lat0", {31'b0, BranchRS_enable}, 32'd0);
    @(negedge clk_in);
    check("t2_lat1", {31'b0, BranchRS_enable}, 32'd1);
    @(negedge clk_in);
    check("t2_lat2", {31'b0, BranchRS_enable}, 32'd0);
    check("t2_hold_pc", BranchRS_pc, 32'h100);

    // Wakeup via CDB bus 1 two edges after dispatch.
    expect_issue(OP_BNE, 32'h77, 32'd2, 4'd5, 32'hFFFF_FFFC, 32'h200);
    dispatch(OP_BNE, 4'd4, 4'd0, 32'd0, 32'd2, 4'd5, 32'hFFFF_FFFC, 32'h200);
    @(negedge clk_in);
    check("t3a_wait", {31'b0, BranchRS_enable}, 32'd0);
    step(1);
    set_cdb(1, 4'd4, 32'h77);
    step(1);
    clr_cdb();
    @(negedge clk_in);
    check("t3a_capture", {31'b0, BranchRS_enable}, 32'd0);
    @(negedge clk_in);
    check("t3a_issue", {31'b0, BranchRS_enable}, 32'd1);

    // Same-cycle forward at dispatch.
    expect_issue(OP_BGE, 32'h55, 32'h55, 4'd6, 32'd12, 32'h220);
    set_cdb(1, 4'd4, 32'h55);
    dispatch(OP_BGE, 4'd4, 4'd0, 32'd0, 32'h55, 4'd6, 32'd12, 32'h220);
    clr_cdb();
    @(negedge clk_in);
    check("t3b_lat0", {31'b0, BranchRS_enable}, 32'd0);
    @(negedge clk_in);
    check("t3b_lat1", {31'b0, BranchRS_enable}, 32'd1);

    // Two buses carrying the same tag: bus 0 wins.
    expect_issue(OP_BLTU, 32'd1, 32'hAA, 4'd7, 32'h10, 32'h240);
    set_cdb(2, 4'd7, 32'hBB);
    set_cdb(0, 4'd7, 32'hAA);
    dispatch(OP_BLTU, 4'd0, 4'd7, 32'd1, 32'd0, 4'd7, 32'h10, 32'h240);
    clr_cdb();
    step(3);

    // Fill all entries, drop the extra dispatch, then drain in index order.
    for (int i = 0; i < 8; i++) begin
      expect_issue(OP_JALR, 32'h1234, 32'(i + 16), 4'(i + 1), 32'(i * 4), 32'(32'h300 + i * 4));
      dispatch(OP_JALR, 4'd9, 4'd0, 32'd0, 32'(i + 16), 4'(i + 1), 32'(i * 4), 32'(32'h300 + i * 4));
    end
    @(negedge clk_in);
    check("t4_full", {31'b0, rs_full}, 32'd1);
    dispatch(OP_JAL, 4'd0, 4'd0, 32'd3, 32'd3, 4'd15, 32'd0, 32'h3F0);
    @(negedge clk_in);
    check("t4_full_after_drop", {31'b0, rs_full}, 32'd1);
    check("t4_drop_no_issue", {31'b0, BranchRS_enable}, 32'd0);
    set_cdb(0, 4'd9, 32'h1234);
    step(1);
    clr_cdb();
    @(negedge clk_in);
    check("t4_capture", {31'b0, BranchRS_enable}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      check("t4_drain_en", {31'b0, BranchRS_enable}, 32'd1);
      if (i == 0) check("t4_full_drop", {31'b0, rs_full}, 32'd0);
    end
    @(negedge clk_in);
    check("t4_drain_done", {31'b0, BranchRS_enable}, 32'd0);

    // Flush with an issue pending and a same-cycle dispatch.
    for (int i = 0; i < 3; i++) dispatch(OP_BLT, 4'd10, 4'd0, 32'd0, 32'd0, 4'(i + 1), 32'd0, 32'h400);
    dispatch(OP_BEQ, 4'd0, 4'd0, 32'd1, 32'd1, 4'd4, 32'd0, 32'h410);
    clear_in = 1'b1;
    disp_valid = 1'b1; disp_op = OP_BLT; disp_qj = '0; disp_qk = '0; disp_dest = 4'd5;
    step(1);
    clear_in = 1'b0;
    disp_valid = 1'b0;
    @(negedge clk_in);
    check("t5_en", {31'b0, BranchRS_enable}, 32'd0);
    check("t5_full", {31'b0, rs_full}, 32'd0);
    set_cdb(0, 4'd10, 32'hDEAD);
    step(1);
    clr_cdb();
    step(4);

    // Pause: ready entry waits out three frozen edges, then issues once.
    expect_issue(OP_BGEU, 32'h11, 32'h22, 4'd9, 32'h20, 32'h500);
    dispatch(OP_BGEU, 4'd0, 4'd0, 32'h11, 32'h22, 4'd9, 32'h20, 32'h500);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      @(negedge clk_in);
      check("t6_paused", {31'b0, BranchRS_enable}, 32'd0);
    end
    check("t6_hold_dest", {28'b0, BranchRS_dest_rob}, 32'd8);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("t6_issue", {31'b0, BranchRS_enable}, 32'd1);
    @(negedge clk_in);
    check("t6_once", {31'b0, BranchRS_enable}, 32'd0);

    step(3);
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
